fetch_ctrl: RTL

Fetch-stage sequencer for the 64-bit pipelined core. It owns the fetch PC register and drives a request/acknowledge instruction-memory port that may have variable latency. It applies branch redirects, including redirects that arrive while a fetch is still outstanding, and holds the fetched instruction in a one-entry output register until decode accepts it. It sits between instruction memory and the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sat_counter.sv | 19 +
 rtl/fetch_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch-stage sequencer
package fetch_pkg;

   typedef enum logic [1:0] {
      F_IDLE  = 2'd0,
      F_FETCH = 2'd1,
      F_KILL  = 2'd2
   } fetch_state_t;

   localparam logic [63:0] PC_INC      = 64'd4;
   localparam int          INSTR_W_DEF = 32;

   // Redirect targets are word aligned; the low two bits are ignored.
   function automatic logic [63:0] align_pc(input logic [63:0] addr);
      return addr & ~64'h3;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - increment-enable saturating counter used by the FETCH_CTRL_PERF_EN counters
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer with redirect/kill handling and one-entry output register
// Optional perf counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int          INSTR_W  = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCSrc_F,
   input  logic [63:0]        PCBranch_F,
   input  logic               stall_D,
   output logic               imem_req,
   output logic [63:0]        imem_addr_F,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               valid_D,
   output logic [INSTR_W-1:0] instr_D,
   output logic [63:0]        pc_D
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_redirect_cnt
`endif
);

   fetch_state_t state, state_nxt;
   logic [63:0]  pc, pc_nxt;
   logic [63:0]  redir_pc, redir_pc_nxt;
   logic [63:0]  target;
   logic         load;

   assign target      = align_pc(PCBranch_F);
   assign imem_addr_F = pc;

   // While a killed request drains, pc keeps the old address so the memory
   // sees a stable request; the redirect target waits in redir_pc.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      redir_pc_nxt = redir_pc;
      imem_req     = 1'b0;
      load         = 1'b0;
      case (state)
         F_IDLE: begin
            state_nxt = F_FETCH;
            if (PCSrc_F) pc_nxt = target;
         end
         F_FETCH: begin
            imem_req = !valid_D || !stall_D;
            if (PCSrc_F) begin
               if (imem_req && !imem_ack) begin
                  redir_pc_nxt = target;
                  state_nxt    = F_KILL;
               end else begin
                  pc_nxt = target;
               end
            end else if (imem_req && imem_ack) begin
               load   = 1'b1;
               pc_nxt = pc + PC_INC;
            end
         end
         F_KILL: begin
            imem_req = 1'b1;
            if (PCSrc_F) redir_pc_nxt = target;
            if (imem_ack) begin
               state_nxt = F_FETCH;
               pc_nxt    = PCSrc_F ? target : redir_pc;
            end
         end
         default: state_nxt = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= F_IDLE;
         pc       <= RESET_PC;
         redir_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         redir_pc <= redir_pc_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_D <= 1'b0;
         instr_D <= '0;
         pc_D    <= '0;
      end else if (load) begin
         valid_D <= 1'b1;
         instr_D <= imem_rdata;
         pc_D    <= pc;
      end else if (PCSrc_F || (valid_D && !stall_D)) begin
         valid_D <= 1'b0;
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   sat_counter #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (valid_D && stall_D),
      .cnt   (perf_stall_cnt)
   );

   sat_counter #(.W(32)) u_redirect_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (PCSrc_F),
      .cnt   (perf_redirect_cnt)
   );
`endif

endmodule
